// File: rtl/cpu_alu_pkg.sv
// Shared CPU-G2 ALU definitions: multiplier state type, default operand width
// and the radix-2 Booth pair encodings.
package cpu_alu_pkg;

    localparam int DEFAULT_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // {Q[0], q_m1} pairs that act on the partial product; 00 and 11 leave it alone.
    localparam logic [1:0] BOOTH_ADD = 2'b01;
    localparam logic [1:0] BOOTH_SUB = 2'b10;

endpackage

// File: rtl/booth_addsub.sv
// Ripple-carry add/subtract of W-bit operands; subtraction uses the inverted
// operand with a carry-in of 1.
module booth_addsub #(
    parameter int W = 33
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_sub,
    output logic [W-1:0] o_sum
);

    logic [W-1:0] w_carry;
    logic [W-1:0] w_b_eff;

    assign w_carry[0] = i_sub;

    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_fa
            assign w_b_eff[gi] = i_b[gi] ^ i_sub;
            assign o_sum[gi]   = i_a[gi] ^ w_b_eff[gi] ^ w_carry[gi];
            // The carry out of the top bit is dropped: the result wraps at W bits.
            if (gi < W - 1) begin : g_carry
                assign w_carry[gi+1] = (i_a[gi] & w_b_eff[gi]) |
                                       (w_carry[gi] & (i_a[gi] ^ w_b_eff[gi]));
            end
        end
    endgenerate

endmodule

// File: rtl/booth_mul_seq.sv
// Sequential radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// signed 2*WIDTH product on z_hi/z_lo. Define MUL_OVF_FLAG_EN to add the ovf output.
module booth_mul_seq
    import cpu_alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_hi,
`ifdef MUL_OVF_FLAG_EN
    output logic [WIDTH-1:0] z_lo,
    output logic             ovf
`else
    output logic [WIDTH-1:0] z_lo
`endif
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t           r_state;
    logic [WIDTH:0]   r_a;
    logic [WIDTH:0]   r_m;
    logic [WIDTH-1:0] r_q;
    logic             r_qm1;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_z_hi;
    logic [WIDTH-1:0] r_z_lo;

    logic [1:0]       w_pair;
    logic             w_sub;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_a_new;
    logic [WIDTH:0]   w_a_sh;
    logic [WIDTH-1:0] w_q_sh;
    logic             w_qm1_sh;

    assign w_pair = {r_q[0], r_qm1};
    assign w_sub  = (w_pair == BOOTH_SUB);

    booth_addsub #(.W(WIDTH + 1)) u_addsub (
        .i_a   (r_a),
        .i_b   (r_m),
        .i_sub (w_sub),
        .o_sum (w_sum)
    );

    assign w_a_new  = (w_pair == BOOTH_ADD || w_pair == BOOTH_SUB) ? w_sum : r_a;
    // Arithmetic shift of {A, Q, q_m1}: A's sign bit is replicated into the top.
    assign w_a_sh   = {w_a_new[WIDTH], w_a_new[WIDTH:1]};
    assign w_q_sh   = {w_a_new[0], r_q[WIDTH-1:1]};
    assign w_qm1_sh = r_q[0];

`ifdef MUL_OVF_FLAG_EN
    logic r_ovf;
    logic w_ovf;

    assign w_ovf = (w_a_sh[WIDTH-1:0] != {WIDTH{w_q_sh[WIDTH-1]}});
    assign ovf   = r_ovf;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && r_count == CW'(1)) begin
            r_ovf <= w_ovf;
        end
    end
`endif

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_m     <= '0;
            r_q     <= '0;
            r_qm1   <= 1'b0;
            r_count <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_z_hi  <= '0;
            r_z_lo  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a     <= '0;
                        r_q     <= multiplier;
                        r_qm1   <= 1'b0;
                        r_m     <= {multiplicand[WIDTH-1], multiplicand};
                        r_count <= CW'(WIDTH);
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_a     <= w_a_sh;
                    r_q     <= w_q_sh;
                    r_qm1   <= w_qm1_sh;
                    r_count <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_z_hi  <= w_a_sh[WIDTH-1:0];
                        r_z_lo  <= w_q_sh;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign z_hi = r_z_hi;
    assign z_lo = r_z_lo;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Self-checking bench for booth_mul_seq: directed cases plus randomized traffic
// against a timestamp-based behavioural model. Honours MUL_OVF_FLAG_EN.
module tb_booth_mul_seq;

    localparam int WIDTH = 32;
    localparam int TMO   = 200;

    logic             clock;
    logic             clear;
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z_hi;
    logic [WIDTH-1:0] z_lo;
`ifdef MUL_OVF_FLAG_EN
    logic             ovf;
`endif

    int n_vec = 0;
    int n_bad = 0;

    booth_mul_seq dut (
        .clock        (clock),
        .clear        (clear),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .z_hi         (z_hi),
`ifdef MUL_OVF_FLAG_EN
        .z_lo         (z_lo),
        .ovf          (ovf)
`else
        .z_lo         (z_lo)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic longint prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return longint'($signed(a)) * longint'($signed(b));
    endfunction

    // Model: remember the edge number of the last accept and the pending product.
    // A request is accepted once WIDTH+2 edges have passed since the previous one.
    int               edge_n   = 0;
    int               acc_edge = -1000;
    longint           pend     = 0;
    logic [WIDTH-1:0] e_hi     = '0;
    logic [WIDTH-1:0] e_lo     = '0;
    logic             e_ovf    = 1'b0;

    always @(posedge clock or negedge clear) begin
        if (!clear) begin
            acc_edge <= -1000;
            e_hi     <= '0;
            e_lo     <= '0;
            e_ovf    <= 1'b0;
        end else begin
            edge_n <= edge_n + 1;
            if (edge_n + 1 >= acc_edge + WIDTH + 2 && start) begin
                acc_edge <= edge_n + 1;
                pend     <= prod(multiplicand, multiplier);
            end
            if (edge_n + 1 == acc_edge + WIDTH) begin
                e_hi  <= pend[63:32];
                e_lo  <= pend[31:0];
                e_ovf <= (pend > 64'sd2147483647) || (pend < -64'sd2147483648);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        chk("busy", 64'(busy), 64'((edge_n - acc_edge) < WIDTH));
        chk("done", 64'(done), 64'((edge_n - acc_edge) == WIDTH));
        chk("z_hi", 64'(z_hi), 64'(e_hi));
        chk("z_lo", 64'(z_lo), 64'(e_lo));
`ifdef MUL_OVF_FLAG_EN
        chk("ovf", 64'(ovf), 64'(e_ovf));
`endif
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    // Waits for done at negedges, counting cycles where busy was seen.
    task automatic wait_done(output int busy_cnt);
        busy_cnt = 0;
        for (int i = 0; i < TMO; i++) begin
            @(negedge clock);
            if (done) return;
            if (busy) busy_cnt++;
        end
        n_vec++;
        n_bad++;
        $display("FAIL wait_done: done not seen within %0d cycles, expected a pulse", TMO);
    endtask

    task automatic run_one(input string name, input logic [31:0] m, input logic [31:0] q,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                           input logic exp_ovf);
        int bc;
        tick();
        multiplicand = m;
        multiplier   = q;
        start        = 1'b1;
        tick();
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
        wait_done(bc);
        chk({name, "_hi"}, 64'(z_hi), 64'(exp_hi));
        chk({name, "_lo"}, 64'(z_lo), 64'(exp_lo));
        chk({name, "_busycyc"}, 64'(bc), 64'd32);
`ifdef MUL_OVF_FLAG_EN
        chk({name, "_ovf"}, 64'(ovf), 64'(exp_ovf));
`else
        if (exp_ovf === 1'bx) $display("unexpected ovf expectation");
`endif
        @(negedge clock);
        chk({name, "_done1cyc"}, 64'(done), 64'd0);
        $display("txn %s: %0h x %0h -> %0h_%0h", name, m, q, z_hi, z_lo);
    endtask

    initial begin
        int     bc;
        time    t1;
        time    t2;
        clear        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #23;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_zlo", 64'(z_lo), 64'd0);
        clear = 1'b1;

        run_one("42x58", 32'd42, 32'd58, 32'h0, 32'h00000984, 1'b0);
        run_one("m7x5", 32'hFFFFFFF9, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFDD, 1'b0);
        run_one("min2", 32'h80000000, 32'h80000000, 32'h40000000, 32'h0, 1'b1);

        // Start pulse during RUN must be ignored.
        tick();
        multiplicand = 32'd105;
        multiplier   = 32'd21;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        multiplicand = 32'd7;
        multiplier   = 32'd7;
        start        = 1'b1;
        tick();
        start = 1'b0;
        wait_done(bc);
        chk("ign_hi", 64'(z_hi), 64'd0);
        chk("ign_lo", 64'(z_lo), 64'h89D);
        $display("txn ignore-in-run: 105 x 21 -> %0h_%0h", z_hi, z_lo);

        // Back-to-back with start held high.
        tick();
        multiplicand = 32'd2;
        multiplier   = 32'd3;
        start        = 1'b1;
        tick();
        multiplicand = 32'd105;
        multiplier   = 32'd21;
        wait_done(bc);
        t1 = $time;
        chk("b2b_first", 64'(z_lo), 64'd6);
        wait_done(bc);
        t2 = $time;
        chk("b2b_second", 64'(z_lo), 64'd2205);
        chk("b2b_spacing", 64'((t2 - t1) / 10), 64'd34);
        tick();
        start = 1'b0;
        $display("txn back-to-back: 6 then %0d, spacing %0d cycles", z_lo, (t2 - t1) / 10);
        repeat (3) tick();

        // Asynchronous clear in the middle of a run.
        multiplicand = 32'h12345678;
        multiplier   = 32'h9ABCDEF0;
        start        = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        #1 clear = 1'b0;
        #1;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_zhi", 64'(z_hi), 64'd0);
        chk("midrst_zlo", 64'(z_lo), 64'd0);
        tick();
        clear = 1'b1;
        $display("txn mid-run clear: outputs %0h/%0h/%0h_%0h", busy, done, z_hi, z_lo);
        run_one("3x4", 32'd3, 32'd4, 32'h0, 32'd12, 1'b0);

        // Randomized traffic, including starts during RUN/DONE and rare clears.
        for (int i = 0; i < 6000; i++) begin
            tick();
            clear = 1'b1;
            if ($urandom_range(0, 3) == 0) begin
                multiplicand = 32'h80000000;
                multiplier   = ($urandom_range(0, 1) == 0) ? 32'h7FFFFFFF : 32'hFFFFFFFF;
            end else begin
                multiplicand = $urandom;
                multiplier   = $urandom;
            end
            start = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 999) == 0) clear = 1'b0;
            if (done) $display("txn random: product %0h_%0h", z_hi, z_lo);
        end
        tick();
        clear = 1'b1;
        start = 1'b0;
        repeat (40) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
